// File: rtl/mem_load_resp.sv
// MEM-stage load unit: issues an SRAM-like read, waits for the handshake,
// extracts and extends the addressed byte/half/word, and flags misaligned loads.
module mem_load_resp (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   input  logic [2:0]  memop,
   input  logic [31:0] addr,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        ld_done,
   output logic        adel,
   output logic [31:0] bad_addr,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   // state     | meaning
   // IDLE      | waiting for a load from MEM
   // REQ       | request on the bus, waiting for addr_ok
   // WAIT      | request accepted, waiting for read data
   // DRAIN_REQ | flushed before addr_ok; request must still complete
   // DRAIN     | flushed after addr_ok; swallow the returning data
   // DONE      | result valid for one cycle
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_DRAIN_REQ, S_DRAIN, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic        is_load, aligned, accept, misalign;
   logic        take_data;

   function automatic logic [31:0] extract(input logic [2:0]  op,
                                           input logic [1:0]  off,
                                           input logic [31:0] rdata);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = rdata >> {off, 3'b000};
      b  = sh[7:0];
      h  = off[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b001:  extract = {24'b0, b};
         3'b010:  extract = {{16{h[15]}}, h};
         3'b011:  extract = {16'b0, h};
         default: extract = rdata;
      endcase
   endfunction

   always_comb begin
      is_load = (memop <= 3'b100);
      case (memop[2:1])
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      misalign  = ld_valid & is_load & ~aligned;
      accept    = ld_valid & is_load & aligned & ~flush;
      take_data = (state == S_WAIT) & data_data_ok & ~flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= 3'b000;
         off_q     <= 2'b00;
         data_addr <= 32'h0;
         data_size <= 2'd0;
         ld_data   <= 32'h0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && accept) begin
            op_q      <= memop;
            off_q     <= addr[1:0];
            data_addr <= addr;
            data_size <= memop[2] ? 2'd2 : (memop[1] ? 2'd1 : 2'd0);
         end
         if (take_data)
            ld_data <= extract(op_q, off_q, data_rdata);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (accept) state_nxt = S_REQ;
         S_REQ:
            if (data_addr_ok) state_nxt = flush ? S_DRAIN : S_WAIT;
            else if (flush)   state_nxt = S_DRAIN_REQ;
         S_DRAIN_REQ:
            if (data_addr_ok) state_nxt = S_DRAIN;
         S_WAIT:
            if (data_data_ok) state_nxt = flush ? S_IDLE : S_DONE;
            else if (flush)   state_nxt = S_DRAIN;
         S_DRAIN:
            if (data_data_ok) state_nxt = S_IDLE;
         S_DONE:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stall    = 1'b0;
      data_req = 1'b0;
      ld_done  = 1'b0;
      adel     = 1'b0;
      bad_addr = 32'h0;
      data_wr  = 1'b0;
      case (state)
         S_IDLE: begin
            stall = accept;
            if (misalign) begin
               adel     = 1'b1;
               bad_addr = addr;
            end
         end
         S_REQ, S_DRAIN_REQ: begin
            stall    = 1'b1;
            data_req = 1'b1;
         end
         S_WAIT, S_DRAIN:
            stall = 1'b1;
         S_DONE:
            ld_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_load_resp.sv
// Directed bench for mem_load_resp: the bench plays the bus slave and checks
// outputs half a cycle after each rising edge.
module tb_mem_load_resp;

   logic        clk = 1'b0;
   logic        rst, ld_valid, flush;
   logic [2:0]  memop;
   logic [31:0] addr;
   logic        stall, ld_done, adel, data_req, data_wr;
   logic [31:0] ld_data, bad_addr, data_addr;
   logic [1:0]  data_size;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   int n_cmp = 0;
   int n_err = 0;

   mem_load_resp dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .memop(memop), .addr(addr),
      .flush(flush), .stall(stall), .ld_data(ld_data), .ld_done(ld_done),
      .adel(adel), .bad_addr(bad_addr), .data_req(data_req), .data_wr(data_wr),
      .data_size(data_size), .data_addr(data_addr), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Full load: ao_dly REQ cycles without addr_ok, then addr_ok; data_ok on
   // the do_dly-th WAIT cycle.
   task automatic run_load(input logic [2:0] op, input logic [31:0] a,
                           input int ao_dly, input int do_dly,
                           input logic [31:0] rd, input logic [31:0] exp_data,
                           input logic [1:0] exp_size);
      ld_valid = 1'b1; memop = op; addr = a;
      #1;
      chk("accept_stall", stall, 1);
      chk("accept_adel", adel, 0);
      chk("accept_noreq", data_req, 0);
      cyc();
      for (int i = 0; i < ao_dly; i++) begin
         chk("req_held", data_req, 1);
         chk("req_stall", stall, 1);
         cyc();
      end
      chk("req_size", data_size, exp_size);
      chk("req_addr", data_addr, a);
      chk("req_wr", data_wr, 0);
      data_addr_ok = 1'b1;
      cyc();
      data_addr_ok = 1'b0;
      #1;
      chk("wait_noreq", data_req, 0);
      for (int i = 1; i < do_dly; i++) begin
         chk("wait_stall", stall, 1);
         chk("wait_nodone", ld_done, 0);
         cyc();
      end
      data_data_ok = 1'b1; data_rdata = rd;
      cyc();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      #1;
      chk("done_pulse", ld_done, 1);
      chk("done_stall", stall, 0);
      chk("done_noreq", data_req, 0);
      chk("ld_data", ld_data, exp_data);
      ld_valid = 1'b0; memop = 3'b000; addr = 32'h0;
      cyc();
      chk("done_one_cycle", ld_done, 0);
      chk("ld_data_held", ld_data, exp_data);
   endtask

   // Present a load and run it into the WAIT state.
   task automatic to_wait(input logic [2:0] op, input logic [31:0] a);
      ld_valid = 1'b1; memop = op; addr = a;
      cyc();
      data_addr_ok = 1'b1;
      cyc();
      data_addr_ok = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; ld_valid = 1'b0; flush = 1'b0; memop = 3'b000; addr = 32'h0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_req", data_req, 0);
      chk("rst_ld_data", ld_data, 0);
      chk("rst_done", ld_done, 0);
      chk("rst_adel", adel, 0);
      chk("rst_size", data_size, 0);
      chk("rst_daddr", data_addr, 0);
      cyc();

      run_load(3'b100, 32'h0000_1000, 2, 3, 32'h8899AABB, 32'h8899AABB, 2'd2);
      run_load(3'b000, 32'h0000_2003, 0, 1, 32'h80FF0011, 32'hFFFFFF80, 2'd0);
      run_load(3'b001, 32'h0000_2003, 1, 1, 32'h80FF0011, 32'h00000080, 2'd0);
      run_load(3'b010, 32'h0000_2002, 0, 2, 32'h80FF0011, 32'hFFFF80FF, 2'd1);
      run_load(3'b011, 32'h0000_2002, 0, 1, 32'h80FF0011, 32'h000080FF, 2'd1);
      run_load(3'b000, 32'h0000_2000, 0, 1, 32'h80FF0011, 32'h00000011, 2'd0);
      run_load(3'b010, 32'h0000_2000, 0, 1, 32'h1234F00D, 32'hFFFFF00D, 2'd1);

      // misaligned loads
      ld_valid = 1'b1; memop = 3'b010; addr = 32'h0000_1001;
      #1;
      chk("lh_adel", adel, 1);
      chk("lh_bad_addr", bad_addr, 32'h0000_1001);
      chk("lh_stall", stall, 0);
      cyc();
      chk("lh_noreq", data_req, 0);
      memop = 3'b100; addr = 32'h0000_1002;
      #1;
      chk("lw_adel", adel, 1);
      chk("lw_bad_addr", bad_addr, 32'h0000_1002);
      chk("lw_stall", stall, 0);
      cyc();
      chk("lw_noreq", data_req, 0);
      ld_valid = 1'b0;
      #1;
      chk("adel_clear", adel, 0);
      chk("bad_addr_clear", bad_addr, 0);
      run_load(3'b001, 32'h0000_1003, 0, 1, 32'hA5000000, 32'h000000A5, 2'd0);

      // flush in REQ before addr_ok
      ld_valid = 1'b1; memop = 3'b100; addr = 32'h0000_3000;
      cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0; ld_valid = 1'b0;
      #1;
      chk("dreq_held", data_req, 1);
      chk("dreq_stall", stall, 1);
      cyc();
      chk("dreq_held2", data_req, 1);
      data_addr_ok = 1'b1;
      cyc();
      data_addr_ok = 1'b0;
      #1;
      chk("drain_noreq", data_req, 0);
      chk("drain_stall", stall, 1);
      data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
      cyc();
      data_data_ok = 1'b0;
      #1;
      chk("drain_nodone", ld_done, 0);
      chk("drain_ld_data", ld_data, 32'h000000A5);
      chk("drain_idle", stall, 0);
      run_load(3'b100, 32'h0000_3004, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 2'd2);

      // flush in WAIT, data two cycles later
      to_wait(3'b100, 32'h0000_4000);
      flush = 1'b1;
      cyc();
      flush = 1'b0; ld_valid = 1'b0;
      #1;
      chk("wflush_stall", stall, 1);
      cyc();
      chk("wflush_nodone", ld_done, 0);
      data_data_ok = 1'b1; data_rdata = 32'h11111111;
      cyc();
      data_data_ok = 1'b0;
      #1;
      chk("wflush_nodone2", ld_done, 0);
      chk("wflush_ld_data", ld_data, 32'hCAFEF00D);
      chk("wflush_idle", stall, 0);

      // flush coincident with data_ok
      to_wait(3'b100, 32'h0000_4004);
      flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h22222222;
      cyc();
      flush = 1'b0; data_data_ok = 1'b0; ld_valid = 1'b0;
      #1;
      chk("coin_nodone", ld_done, 0);
      chk("coin_idle", stall, 0);
      chk("coin_ld_data", ld_data, 32'hCAFEF00D);

      // reset during WAIT
      to_wait(3'b100, 32'h0000_5000);
      rst = 1'b1; ld_valid = 1'b0;
      cyc();
      chk("wrst_stall", stall, 0);
      chk("wrst_req", data_req, 0);
      chk("wrst_daddr", data_addr, 0);
      chk("wrst_size", data_size, 0);
      chk("wrst_ld_data", ld_data, 0);
      chk("wrst_done", ld_done, 0);
      chk("wrst_adel", adel, 0);
      chk("wrst_bad", bad_addr, 0);
      rst = 1'b0;
      cyc();

      // LW then SW with ld_valid held: one read only
      to_wait(3'b100, 32'h0000_6000);
      data_data_ok = 1'b1; data_rdata = 32'h0BADC0DE;
      cyc();
      data_data_ok = 1'b0;
      #1;
      chk("b2b_done", ld_done, 1);
      chk("b2b_noreq_done", data_req, 0);
      chk("b2b_data", ld_data, 32'h0BADC0DE);
      memop = 3'b111; addr = 32'h0000_6004;
      cyc();
      chk("sw_noreq", data_req, 0);
      chk("sw_stall", stall, 0);
      cyc();
      chk("sw_noreq2", data_req, 0);
      chk("sw_nodone", ld_done, 0);
      ld_valid = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_load_resp.md
Name: mem_load_resp

Overview:
- Read-side counterpart of the MEM-stage store byte-lane/exception logic.
- Takes a load from MEM stage, issues an SRAM-like read on the data bus and waits for the handshake.
- Extracts the addressed byte/half/word and sign- or zero-extends it.
- Stalls the pipeline until the result is ready; raises the load address-error exception for misaligned loads and sends no bus request for them.

Parameters:
- none (fixed 32-bit datapath, 32-bit addresses)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ld_valid  in  1  MEM stage holds a valid memory-read instruction
- memop  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; 101-111 are stores, ignored here
- addr  in  32  effective address
- flush  in  1  exception/flush from later stage; cancels the current load
- stall  out  1  freeze pipeline
- ld_data  out  32  extended load result
- ld_done  out  1  one-cycle pulse, ld_data valid
- adel  out  1  load address error
- bad_addr  out  32  faulting address when adel=1, else 0
- data_req  out  1  bus request
- data_wr  out  1  tied 0
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  request address
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data returned
- data_rdata  in  32  read data

Behaviour:
- Reset values:
  - FSM=IDLE, data_req=0, data_size=0, data_addr=0
  - ld_data=0, ld_done=0
  - latched memop/offset=0
  - stall=0, adel=0, bad_addr=0
- Reset in any state returns to IDLE and abandons any outstanding transaction; the bus slave resets on the same rst.
- Accept condition in IDLE: ld_valid & memop<=100 & aligned & !flush.
  - Aligned means: LH/LHU addr[0]=0; LW addr[1:0]=00; LB/LBU always.
- Misalignment (IDLE only, combinational):
  - ld_valid & misaligned load -> adel=1, bad_addr=addr, no request, stall=0, stay IDLE.
- stall (combinational):
  - IDLE: stall = accept condition.
  - REQ, WAIT, DRAIN_REQ, DRAIN: stall=1.
  - DONE: stall=0.
- States:
  - IDLE: on accept, latch memop, addr[1:0] and addr, set data_req=1, data_addr=addr, data_size from memop -> REQ.
  - REQ: data_req held high with stable addr/size until data_addr_ok.
    - data_addr_ok & !flush -> WAIT, data_req=0.
    - data_addr_ok & flush -> DRAIN, data_req=0.
    - !data_addr_ok & flush -> DRAIN_REQ (request is never withdrawn).
  - DRAIN_REQ: keep data_req until data_addr_ok -> DRAIN.
  - WAIT: data_data_ok & !flush -> register extracted value into ld_data -> DONE. flush without data_ok -> DRAIN. flush coincident with data_ok -> discard the data -> IDLE.
  - DRAIN: on data_data_ok discard the data, no ld_done -> IDLE.
  - DONE: ld_done=1 for exactly this cycle, ld_data held. ld_valid is ignored (same instruction still presented) -> IDLE.
- data_data_ok is only sampled in WAIT/DRAIN. The slave never returns data in the same cycle as its addr_ok. Minimum load latency is request cycle + 1 WAIT cycle + DONE.
- Extraction uses the latched offset off=addr[1:0]:
  - LB: sign-extend rdata[8*off+7 : 8*off]. LBU: same byte, zero-extended.
  - LH: sign-extend rdata[15:0] when off=00, rdata[31:16] when off=10. LHU: same halves, zero-extended.
  - LW: rdata unchanged.
- ld_data keeps its value until the next DONE. A flushed load never updates ld_data.
- flush in IDLE/DONE has no effect besides blocking a new accept.

Test Plan:
- LW addr=0x1000, rdata=0x8899AABB, addr_ok after 2 cycles, data_ok 3 cycles later -> data_size=2; stall high from accept to DONE; ld_done pulse; ld_data=0x8899AABB.
- LB off=3 and LBU off=3, rdata=0x80FF0011 -> ld_data=0xFFFFFF80 and 0x00000080; LH off=2 and LHU off=2 -> 0xFFFF80FF and 0x000080FF; data_size=0 for LB/LBU, 1 for LH/LHU.
- LH addr=0x1001, then LW addr=0x1002 -> adel=1, bad_addr=addr, data_req never asserted, stall=0; LBU addr=0x1003 -> no adel.
- Flush in REQ before addr_ok -> data_req stays high until addr_ok, data_ok consumed in DRAIN, no ld_done, ld_data unchanged, next load proceeds normally.
- Flush in WAIT, data_ok 2 cycles later -> DRAIN, data discarded, no ld_done; rst asserted in WAIT -> all outputs at reset values next cycle.
- Back-to-back LW then SW (memop=111) with ld_valid held -> single bus read, no re-issue in DONE, store ignored (no data_req).
